// File: rtl/seeg_stim_sequencer.sv
// seeg_stim_sequencer: biphasic stimulation timing for the sEEG front end, durations counted in frame ticks
module seeg_stim_sequencer #(
    parameter int CNT_W = 16,
    parameter int AMP_W = 8
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             tick_i,
    input  logic             stim_finite_mode_start_i,
    input  logic             stim_infinite_mode_start_i,
    input  logic             stim_infinite_mode_stop_i,
    input  logic [CNT_W-1:0] stim_pulse_length_i,
    input  logic [AMP_W-1:0] stim_pulse_magnitude_i,
    input  logic [CNT_W-1:0] stim_inter_pulse_delay_i,
    input  logic [CNT_W-1:0] stim_inter_bipulse_delay_i,
    input  logic [CNT_W-1:0] stim_inter_train_delay_i,
    input  logic [CNT_W-1:0] stim_bipulses_per_train_count_i,
    input  logic [CNT_W-1:0] stim_train_count_i,
    input  logic [CNT_W-1:0] stim_charge_recovery_time_i,
    input  logic             stim_rising_edge_first_i,
    output logic             stim_on_o,
    output logic             stim_pol_o,
    output logic [AMP_W-1:0] stim_amp_o,
    output logic             charge_recovery_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             cfg_error_o
);
    typedef enum logic [2:0] {IDLE, PH1, IPD, PH2, IBD, RECOV, ITD} state_e;
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
    state_e           state_q, state_d, post_recov, to_recov;
    logic [CNT_W-1:0] cnt_q, cnt_d, bp_q, bp_d, tr_q, tr_d, dur;
    logic [CNT_W-1:0] len_q, ipd_q, ibd_q, itd_q, bpn_q, trn_q, rec_q;
    logic [AMP_W-1:0] mag_q;
    logic             ref_q, inf_q, stop_q, stop_d, done_q, done_d, err_q, err_d;
    logic             start, bad, accept, expire, stop_now, more_tr, last_bp;
    assign start  = stim_finite_mode_start_i | stim_infinite_mode_start_i;
    assign bad    = stim_pulse_length_i == '0 || stim_bipulses_per_train_count_i == '0 ||
                    (stim_finite_mode_start_i && stim_train_count_i == '0);
    assign dur    = (state_q == PH1 || state_q == PH2) ? len_q :
                    state_q == IPD   ? ipd_q :
                    state_q == IBD   ? ibd_q :
                    state_q == RECOV ? rec_q :
                    state_q == ITD   ? itd_q : '0;
    assign expire = tick_i && cnt_q == dur - ONE;
    // A stop strobe counts on the clk it arrives, even when a tick lands on the same clk
    assign stop_now   = stop_q | (stim_infinite_mode_stop_i & inf_q & (state_q != IDLE));
    assign more_tr    = inf_q ? !stop_now : (tr_q + ONE < trn_q);
    assign last_bp    = stop_now || (bp_q + ONE == bpn_q);
    assign post_recov = more_tr ? (itd_q == '0 ? PH1 : ITD) : IDLE;
    assign to_recov   = rec_q == '0 ? post_recov : RECOV;
    // Next-state: zero-length delay states are resolved in the same clk so they never appear
    always_comb begin
        state_d = state_q;
        cnt_d   = tick_i ? cnt_q + ONE : cnt_q;
        bp_d    = bp_q;
        tr_d    = tr_q;
        err_d   = 1'b0;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (start) begin
                    err_d   = bad;
                    accept  = !bad;
                    state_d = bad ? IDLE : PH1;
                    bp_d    = '0;
                    tr_d    = '0;
                end
            end
            PH1: if (expire) state_d = ipd_q == '0 ? PH2 : IPD;
            IPD: if (expire) state_d = PH2;
            PH2: if (expire) begin
                bp_d    = last_bp ? '0 : bp_q + ONE;
                state_d = last_bp ? to_recov : (ibd_q == '0 ? PH1 : IBD);
                if (last_bp && rec_q == '0 && more_tr) tr_d = tr_q + ONE;
            end
            IBD: if (stop_now) state_d = to_recov; else if (expire) state_d = PH1;
            RECOV: if (expire) begin
                state_d = post_recov;
                if (more_tr) tr_d = tr_q + ONE;
            end
            ITD: if (stop_now) state_d = to_recov; else if (expire) state_d = PH1;
            default: state_d = IDLE;
        endcase
        if (state_d != state_q) cnt_d = '0;
        done_d = state_d == IDLE && state_q != IDLE;
        stop_d = state_d == IDLE ? 1'b0 : stop_now;
    end
    // Sequencer state, tick counter and bipulse/train indices
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bp_q    <= '0;
            tr_q    <= '0;
            stop_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bp_q    <= bp_d;
            tr_q    <= tr_d;
            stop_q  <= stop_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end
    // Configuration snapshot taken only on an accepted start, so mid-run edits are inert
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            len_q <= '0;
            ipd_q <= '0;
            ibd_q <= '0;
            itd_q <= '0;
            bpn_q <= '0;
            trn_q <= '0;
            rec_q <= '0;
            mag_q <= '0;
            ref_q <= 1'b0;
            inf_q <= 1'b0;
        end else if (accept) begin
            len_q <= stim_pulse_length_i;
            ipd_q <= stim_inter_pulse_delay_i;
            ibd_q <= stim_inter_bipulse_delay_i;
            itd_q <= stim_inter_train_delay_i;
            bpn_q <= stim_bipulses_per_train_count_i;
            trn_q <= stim_train_count_i;
            rec_q <= stim_charge_recovery_time_i;
            mag_q <= stim_pulse_magnitude_i;
            ref_q <= stim_rising_edge_first_i;
            inf_q <= !stim_finite_mode_start_i;
        end
    end
    assign stim_on_o         = state_q == PH1 || state_q == PH2;
    assign stim_pol_o        = (state_q == PH1 && ref_q) || (state_q == PH2 && !ref_q);
    assign stim_amp_o        = stim_on_o ? mag_q : '0;
    assign charge_recovery_o = state_q == RECOV;
    assign busy_o            = state_q != IDLE;
    assign done_o            = done_q;
    assign cfg_error_o       = err_q;
endmodule

// File: tb/tb_seeg_stim_sequencer.sv
// tb_seeg_stim_sequencer: scoreboard bench comparing output segments of the stim sequencer
module tb_seeg_stim_sequencer;
    logic        clk = 1'b0, rstn = 1'b0, tick = 1'b0;
    logic        fin_s = 1'b0, inf_s = 1'b0, stop_s = 1'b0;
    logic [15:0] len = '0, ipd = '0, ibd = '0, itd = '0, bpn = '0, trn = '0, rec = '0;
    logic [7:0]  mag = '0;
    logic        rf = 1'b0;
    logic        stim_on, stim_pol, charge_recovery, busy, done, cfg_error;
    logic [7:0]  stim_amp;

    typedef struct {
        logic [11:0] code;
        int          len;
    } seg_t;
    seg_t        sb_q[$];
    seg_t        mon_e;
    int          n_cmp = 0, n_bad = 0;
    int          done_cnt = 0, busy_cnt = 0, ph1_cnt = 0, exp_total = 0;
    int          tick_div = 1, tphase = 0, cur_len = 0;
    logic [11:0] cur_code = '0, mon_code, ph1_code = '0;
    bit          mon_en = 1'b1;

    seeg_stim_sequencer dut (
        .clk_i(clk), .rstn_i(rstn), .tick_i(tick),
        .stim_finite_mode_start_i(fin_s), .stim_infinite_mode_start_i(inf_s),
        .stim_infinite_mode_stop_i(stop_s),
        .stim_pulse_length_i(len), .stim_pulse_magnitude_i(mag),
        .stim_inter_pulse_delay_i(ipd), .stim_inter_bipulse_delay_i(ibd),
        .stim_inter_train_delay_i(itd), .stim_bipulses_per_train_count_i(bpn),
        .stim_train_count_i(trn), .stim_charge_recovery_time_i(rec),
        .stim_rising_edge_first_i(rf),
        .stim_on_o(stim_on), .stim_pol_o(stim_pol), .stim_amp_o(stim_amp),
        .charge_recovery_o(charge_recovery), .busy_o(busy), .done_o(done), .cfg_error_o(cfg_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] mk(input bit on, input bit pol, input bit rc, input logic [7:0] a);
        return {1'b1, on, pol, rc, a};
    endfunction

    task automatic push(input logic [11:0] c, input int n);
        seg_t s;
        s.code = c;
        s.len  = n;
        sb_q.push_back(s);
        exp_total += n;
    endtask

    // frame tick generator: one tick every tick_div clks
    always @(negedge clk) begin
        tick   = (tphase == 0);
        tphase = (tphase + 1 >= tick_div) ? 0 : tphase + 1;
    end

    // segment monitor: closes a run of identical busy outputs and checks it against the scoreboard
    always @(negedge clk) begin
        mon_code = {busy, stim_on, stim_pol, charge_recovery, stim_amp};
        if (done === 1'b1) done_cnt++;
        if (busy === 1'b1) busy_cnt++;
        if (mon_code === cur_code) cur_len++;
        else begin
            if (mon_en && cur_code[11] === 1'b1) begin
                if (sb_q.size() == 0) chk("extra_seg", 32'(cur_code), 0);
                else begin
                    mon_e = sb_q.pop_front();
                    chk("seg_code", 32'(cur_code), 32'(mon_e.code));
                    chk("seg_len", 32'(cur_len), 32'(mon_e.len));
                end
            end
            cur_code = mon_code;
            cur_len  = 1;
            if (mon_code === ph1_code) ph1_cnt++;
        end
    end

    task automatic cfg(input int l, input int m, input int pd, input int bd, input int td,
                       input int bp, input int tr, input int rc, input bit r, input int k);
        len = 16'(l); mag = 8'(m); ipd = 16'(pd); ibd = 16'(bd); itd = 16'(td);
        bpn = 16'(bp); trn = 16'(tr); rec = 16'(rc); rf = r;
        ph1_code = mk(1, r, 0, 8'(m));
        tick_div = k;
        tphase   = 0;
    endtask

    // expected segment list, built from the configuration alone
    task automatic setup(input int l, input int m, input int pd, input int bd, input int td,
                         input int bp, input int tr, input int rc, input bit r, input int k,
                         input int stop_tr);
        int ntr, nbp;
        cfg(l, m, pd, bd, td, bp, tr, rc, r, k);
        exp_total = 0;
        ntr = stop_tr >= 0 ? stop_tr + 1 : tr;
        for (int t = 0; t < ntr; t++) begin
            nbp = (t == stop_tr) ? 1 : bp;
            for (int b = 0; b < nbp; b++) begin
                push(mk(1, r, 0, 8'(m)), l * k);
                if (pd > 0) push(mk(0, 0, 0, 0), pd * k);
                push(mk(1, !r, 0, 8'(m)), l * k);
                if (b < nbp - 1 && bd > 0) push(mk(0, 0, 0, 0), bd * k);
            end
            if (rc > 0) push(mk(0, 0, 1, 0), rc * k);
            if (t < ntr - 1 && td > 0) push(mk(0, 0, 0, 0), td * k);
        end
    endtask

    task automatic strobe(input bit f, input bit i);
        for (int n = 0; n < 16; n++) begin
            @(negedge clk); #1;
            if (tick) break;
        end
        fin_s = f; inf_s = i;
        @(negedge clk); #1;
        fin_s = 1'b0; inf_s = 1'b0;
    endtask

    task automatic run_job(input string name, input bit f, input bit i, input int stop_at,
                           input bit disturb);
        int  d0, b0;
        bit  ended, stopped;
        d0 = done_cnt; b0 = busy_cnt; ph1_cnt = 0; ended = 0; stopped = 0;
        strobe(f, i);
        for (int n = 0; n < 5000; n++) begin
            @(negedge clk); #1;
            if (!busy) begin
                ended = 1;
                break;
            end
            if (stop_at > 0 && !stopped && ph1_cnt >= stop_at) begin
                stopped = 1;
                stop_s  = 1'b1;
                @(posedge clk); #1;
                stop_s  = 1'b0;
            end
            if (disturb && n == 20) begin
                len = 16'd5; mag = 8'd1; bpn = 16'd1; trn = 16'd1; rf = ~rf;
                fin_s = 1'b1;
                @(posedge clk); #1;
                fin_s = 1'b0;
            end
        end
        chk({name, "_ended"}, 32'(ended), 1);
        @(negedge clk); #1;
        chk({name, "_done_pulses"}, 32'(done_cnt - d0), 1);
        chk({name, "_busy_clks"}, 32'(busy_cnt - b0), 32'(exp_total));
        chk({name, "_sb_left"}, 32'(sb_q.size()), 0);
        sb_q.delete();
    endtask

    task automatic reject(input string name, input bit f);
        @(negedge clk); #1;
        fin_s = f; inf_s = !f;
        @(negedge clk); #1;
        fin_s = 1'b0; inf_s = 1'b0;
        chk({name, "_err"}, 32'(cfg_error), 1);
        chk({name, "_busy"}, 32'(busy), 0);
        @(negedge clk); #1;
        chk({name, "_err_clr"}, 32'(cfg_error), 0);
        chk({name, "_idle"}, 32'(busy), 0);
    endtask

    initial begin
        int  d0;
        bit  found;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_outs", 32'({stim_on, stim_pol, stim_amp, charge_recovery, busy, done, cfg_error}), 0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        // long finite run, config scrambled and a second start strobed while busy
        setup(2, 40, 3, 3, 12, 4, 4, 8, 1'b1, 1, -1);
        chk("t1_total_ticks", 32'(exp_total), 216);
        run_job("t1", 1'b1, 1'b0, 0, 1'b1);
        // reversed polarity, amplitude 100, stop strobe during finite run ignored
        setup(3, 100, 1, 2, 4, 2, 2, 3, 1'b0, 1, -1);
        run_job("t2", 1'b1, 1'b0, 2, 1'b0);
        // infinite run stopped in the first PH1 of train 3
        setup(2, 77, 3, 3, 12, 4, 0, 8, 1'b1, 1, 2);
        run_job("t3", 1'b0, 1'b1, 9, 1'b0);
        // all delays zero; both start strobes together, finite wins
        setup(1, 9, 0, 0, 0, 3, 2, 2, 1'b1, 1, -1);
        run_job("t4", 1'b1, 1'b1, 0, 1'b0);
        // rejected starts
        cfg(0, 5, 1, 1, 1, 2, 2, 2, 1'b1, 1);
        reject("len0", 1'b1);
        cfg(2, 5, 1, 1, 1, 2, 0, 2, 1'b1, 1);
        reject("trains0", 1'b1);
        cfg(2, 5, 1, 1, 1, 0, 2, 2, 1'b1, 1);
        reject("bp0", 1'b0);
        // async reset in the middle of PH2
        mon_en = 1'b0;
        cfg(3, 50, 1, 1, 1, 2, 0, 2, 1'b1, 1);
        strobe(1'b0, 1'b1);
        found = 0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk); #1;
            if (stim_on && !stim_pol) begin
                found = 1;
                break;
            end
        end
        chk("rst_ph2_seen", 32'(found), 1);
        d0 = done_cnt;
        #2 rstn = 1'b0;
        #1;
        chk("rst_async_busy", 32'(busy), 0);
        chk("rst_async_outs", 32'({stim_on, stim_pol, stim_amp, charge_recovery, done, cfg_error}), 0);
        repeat (2) @(negedge clk);
        #1 rstn = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_no_done", 32'(done_cnt - d0), 0);
        chk("rst_idle", 32'(busy), 0);
        mon_en = 1'b1;
        // normal run after reset with one tick every 4 clks
        setup(2, 33, 1, 2, 3, 2, 2, 2, 1'b1, 4, -1);
        chk("t6_total_clks", 32'(exp_total), 124);
        run_job("t6", 1'b1, 1'b0, 0, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
